// File: rtl/if_stage.sv
// if_stage: in-order fetch with up to 2 requests in flight, 2-entry {pc, instr} buffer and redirect drop.
// Optional same-cycle response bypass when IF_RESP_BYPASS_EN is defined.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_flow_t;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output if_id_flow_t outflow,
  output logic        out_valid
);
  logic [31:0] pc;
  logic [31:0] buf_pc [2];
  logic [31:0] buf_instr [2];
  logic [31:0] pcq [2];
  logic        head, tail, pq_head, pq_tail;
  logic [1:0]  count, inflight, drop_cnt;
  logic        has_head, byp, fire, pop, keep, push;
  assign has_head = count != 2'd0;
`ifdef IF_RESP_BYPASS_EN
  assign byp = !reset && !redirect && !has_head && drop_cnt == 2'd0 && imem_resp_valid;
`else
  assign byp = 1'b0;
`endif
  // credits come from registered count, so a same-cycle pop frees nothing until next cycle
  assign imem_req_valid = !reset && !redirect && ({1'b0, count} + {1'b0, inflight} < 3'd2);
  assign imem_req_addr  = reset ? RESET_PC : pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign out_valid      = !reset && !redirect && (has_head || byp);
  assign pop            = !reset && !redirect && has_head && !stall;
  assign keep           = imem_resp_valid && drop_cnt == 2'd0 && !redirect;
  assign push           = keep && !(byp && !stall);
  assign outflow = reset                  ? {RESET_PC, NOP_INSTR}
                 : (!redirect && has_head) ? {buf_pc[head], buf_instr[head]}
                 : byp                    ? {pcq[pq_head], imem_resp_data}
                 :                          {pc, NOP_INSTR};
  // pc queue advances on every response, dropped or kept, to stay aligned with in-flight requests
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      head     <= 1'b0;
      tail     <= 1'b0;
      pq_head  <= 1'b0;
      pq_tail  <= 1'b0;
      count    <= 2'd0;
      inflight <= 2'd0;
      drop_cnt <= 2'd0;
    end else begin
      if (fire) begin
        pcq[pq_tail] <= pc;
        pq_tail      <= ~pq_tail;
      end
      if (imem_resp_valid) pq_head <= ~pq_head;
      if (push) begin
        buf_pc[tail]    <= pcq[pq_head];
        buf_instr[tail] <= imem_resp_data;
      end
      pc       <= redirect ? redirect_pc : fire ? pc + 32'd4 : pc;
      inflight <= inflight + {1'b0, fire} - {1'b0, imem_resp_valid};
      drop_cnt <= redirect ? inflight - {1'b0, imem_resp_valid}
                           : drop_cnt - {1'b0, imem_resp_valid && drop_cnt != 2'd0};
      count    <= redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      head     <= redirect ? 1'b0 : head ^ pop;
      tail     <= redirect ? 1'b0 : tail ^ push;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized fetch-stage bench against a queue-based request/buffer model.
module tb_if_stage;
  import if_stage_pkg::*;
  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_resp_valid, redirect, stall, out_valid;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc;
  if_id_flow_t outflow;
  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .outflow(outflow), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] pc; bit drop; } req_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;
  req_t        outq[$];
  if_id_flow_t fbuf[$];
  mem_t        memq[$];
  logic [31:0] m_pc;
  int          cyc = 0, total = 0, bad = 0;
  int          lat_min = 1, lat_max = 1, resp_pct = 100;
  logic        byp, fire_m, exp_rv, exp_ov;
  logic [31:0] exp_addr;
  if_id_flow_t exp_of;
  logic [97:0] exp_vec;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
  endfunction

  task automatic drive();
    imem_resp_valid = !reset && memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < resp_pct;
    imem_resp_data  = imem_resp_valid ? memf(memq[0].addr) : $urandom;
  endtask

  task automatic cyc_io();
    logic hd;
    drive();
    @(negedge clk);
    hd  = outq.size() > 0 && outq[0].drop;
    byp = 1'b0;
`ifdef IF_RESP_BYPASS_EN
    byp = !reset && !redirect && fbuf.size() == 0 && !hd && imem_resp_valid;
`endif
    exp_rv   = !reset && !redirect && (fbuf.size() + outq.size() < 2);
    exp_addr = reset ? RST_PC : m_pc;
    exp_ov   = !reset && !redirect && (fbuf.size() > 0 || byp);
    if (reset) exp_of = {RST_PC, NOP};
    else if (!redirect && fbuf.size() > 0) exp_of = fbuf[0];
    else if (byp) exp_of = {outq[0].pc, imem_resp_data};
    else exp_of = {m_pc, NOP};
    fire_m  = exp_rv && imem_req_ready;
    exp_vec = {exp_rv, exp_addr, exp_ov, exp_of};
  endtask

  task automatic advance();
    req_t e;
    @(posedge clk);
    if (reset) begin
      outq.delete(); fbuf.delete(); memq.delete();
      m_pc = RST_PC;
    end else begin
      if (!redirect && !stall && fbuf.size() > 0) void'(fbuf.pop_front());
      if (imem_resp_valid) begin
        e = outq.pop_front();
        void'(memq.pop_front());
        if (!redirect && !e.drop && !(byp && !stall)) fbuf.push_back({e.pc, imem_resp_data});
      end
      if (redirect) begin
        fbuf.delete();
        foreach (outq[i]) outq[i].drop = 1'b1;
        m_pc = redirect_pc;
      end else if (fire_m) begin
        outq.push_back('{m_pc, 1'b0});
        memq.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min))});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic set_in(input logic rs, input logic rd, input logic [31:0] rpc, input logic st, input logic rdy);
    reset = rs; redirect = rd; redirect_pc = rpc; stall = st; imem_req_ready = rdy;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, $urandom, $urandom_range(1), $urandom_range(1));
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_stream();
    logic [31:0] nxt = RST_PC;
    lat_min = 1; lat_max = 1; resp_pct = 100;
    for (int i = 0; i < 30; i++) begin
      set_in(0, 0, $urandom, 0, 1);
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      if (out_valid) begin
        total++;
        if (outflow.pc !== nxt || outflow.instr !== memf(nxt)) begin
          bad++; $display("FAIL stream_order got pc=%h instr=%h exp pc=%h instr=%h", outflow.pc, outflow.instr, nxt, memf(nxt));
        end
        nxt = nxt + 32'd4;
      end
      advance();
    end
  endtask

  task automatic test_stall();
    if_id_flow_t held;
    for (int i = 0; i < 12 && fbuf.size() < 2; i++) begin
      set_in(0, 0, $urandom, 1, 1);
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL stall_fill cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      advance();
    end
    total++;
    if (fbuf.size() < 2) begin bad++; $display("FAIL stall_timeout buffer depth %0d required 2", fbuf.size()); end
    held = fbuf[0];
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, $urandom, 1, 1);
      cyc_io();
      total += 2;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || outflow !== held) begin
        bad++; $display("FAIL stall_hold got rv=%b ov=%b of=%h exp rv=0 ov=1 of=%h", imem_req_valid, out_valid, outflow, held);
      end
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, $urandom, 0, 1);
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL stall_resume cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && outq.size() < 2; i++) begin
      set_in(0, 0, $urandom, 0, 1);
      cyc_io();
      advance();
    end
    total++;
    if (outq.size() < 2) begin bad++; $display("FAIL redirect_timeout inflight %0d required 2", outq.size()); end
    set_in(0, 1, 32'h100, 0, 1);
    cyc_io();
    total += 2;
    if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
      bad++; $display("FAIL redirect cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
    end
    if (out_valid !== 1'b0 || outflow.instr !== NOP || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL redirect_cycle got ov=%b instr=%h rv=%b exp ov=0 instr=%h rv=0", out_valid, outflow.instr, imem_req_valid, NOP);
    end
    advance();
    lat_min = 1; lat_max = 2;
    for (int i = 0; i < 15; i++) begin
      set_in(0, 0, $urandom, 0, 1);
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL redirect_after cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      if (out_valid) begin
        total++;
        if (outflow.pc < 32'h100) begin bad++; $display("FAIL redirect_wrongpath got pc=%h exp pc>=100", outflow.pc); end
      end
      advance();
    end
  endtask

  task automatic test_ready_low();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, $urandom, 0, i >= 4);
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL ready_low cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_double_redirect();
    lat_min = 2; lat_max = 4;
    for (int i = 0; i < 10 && outq.size() < 2; i++) begin
      set_in(0, 0, $urandom, 0, 1);
      cyc_io();
      advance();
    end
    for (int i = 0; i < 25; i++) begin
      set_in(0, i < 2, i == 0 ? 32'h200 : 32'h300, 0, 1);
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL dbl_redirect cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      if (out_valid) begin
        total++;
        if (outflow.pc < 32'h300) begin bad++; $display("FAIL dbl_redirect_path got pc=%h exp pc>=300", outflow.pc); end
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 14; i++) begin
      set_in(0, i == 0, 32'hFFFF_FFF6, 0, 1);
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 4; resp_pct = 70;
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(99) < 2, $urandom_range(99) < 6, $urandom, $urandom_range(99) < 25, $urandom_range(99) < 70);
      if (reset) redirect = 1'b0;
      cyc_io();
      total++;
      if ({imem_req_valid, imem_req_addr, out_valid, outflow} !== exp_vec) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {imem_req_valid, imem_req_addr, out_valid, outflow}, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0);
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_low();
    test_double_redirect();
    test_wrap();
    test_random();
    test_reset();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
